stream_mux: RTL and testbench
=============================

# stream_mux

Parametrised N-to-1 streaming multiplexer with valid/ready handshaking and a registered output stage, the successor to the fixed 16:1 single-bit combinational mux tree. Selects one of CHANNELS input streams, each WIDTH bits wide, by explicit select or, when compiled in, by round-robin arbitration. Forwards the chosen word through a one-entry output register at one word per cycle. Sits between multiple producers (register-file read ports, peripheral result buses) and a single consumer in the NovaEdge32 datapath.

## Interface
- WIDTH, 32, data width per channel (>=1)
- CHANNELS, 16, number of input channels (>=2, need not be a power of two)
- SEL_W, derived localparam, $clog2(CHANNELS)
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready, combinational, at most one bit set
- sel  input  SEL_W  explicit channel select (fixed mode)
- rr_mode  input  1  1 = round-robin arbitration, 0 = explicit select (ignored without STREAM_MUX_RR_EN)
- out_data  output  WIDTH  registered selected word
- out_chan  output  SEL_W  registered index of the channel out_data came from
- out_valid  output  1  output register holds a word
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- accept = !out_valid | out_ready: the output register can load this cycle.
- Grant index g:
  - Fixed mode: g = sel.
  - Round-robin mode: g = first k with in_valid[k], searching ptr, ptr+1, ... modulo CHANNELS.
- in_ready[g] = accept & rst_n. All other in_ready bits are 0.
- If sel >= CHANNELS, or no channel is valid in round-robin mode, there is no grant and in_ready is all 0.
- Input transfer: in_valid[g] & in_ready[g]. On the next edge out_data <= word of channel g, out_chan <= g, out_valid <= 1.
- Output transfer: out_valid & out_ready. If there is no simultaneous input transfer, out_valid <= 0. out_data and out_chan keep their value.
- Round-robin pointer ptr (SEL_W bits, reset 0):
  - On an input transfer in round-robin mode, ptr <= g+1.
  - ptr wraps from CHANNELS-1 to 0.
  - Otherwise ptr holds.
- Stall: while out_valid & !out_ready, out_data, out_chan and out_valid are stable. Changes on sel or rr_mode do not affect the held word.
- Mode or sel changes take effect on the next grant only. ptr is not cleared by a mode change.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=0. in_ready is all 0 while rst_n=0.
- Reset assertion mid-operation discards the held word immediately (asynchronous). The first grant after deassertion starts from channel 0.
- Latency: a word accepted at edge n appears on out_data/out_valid after edge n, i.e. 1 cycle.
- Throughput: 1 word/cycle with out_ready held high. Simultaneous drain and fill in the same cycle is required.
- in_ready may depend combinationally on in_valid (round-robin mode) and out_ready. Producers must not make in_valid depend on in_ready.
- Once a producer asserts in_valid, it holds in_valid and data until the transfer completes.

## Configuration
- STREAM_MUX_RR_EN defined: the round-robin arbiter and ptr are compiled in, and rr_mode selects the mode.
- STREAM_MUX_RR_EN undefined: only fixed mode exists. rr_mode is ignored, ptr logic is absent, and behaviour is identical to rr_mode=0.

## Test plan
- Reset/idle: hold rst_n=0 with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_chan=0. Release -> first transfer on the selected channel 1 cycle later.
- Fixed select streaming (CHANNELS=16, WIDTH=32): sel=5, ch5 streams 0xA0..0xA9 with out_ready=1 -> 10 words in order, out_chan=5, one per cycle. No other in_ready bit is ever set.
- Backpressure: out_ready=0 for 4 cycles after the first word 0x1234, with sel toggled meanwhile -> out_data=0x1234 and out_chan stay stable, in_ready=0, no word lost or duplicated.
- Round-robin fairness (macro defined, rr_mode=1): channels 0, 3 and 15 continuously valid -> out_chan sequence 0, 3, 15, 0, 3 ... Wrap from 15 to 0 is confirmed.
- Out-of-range select (CHANNELS=12): sel=13 with all in_valid=1 -> in_ready all 0 and out_valid stays 0.
- Mid-stream reset: rst_n pulsed low while out_valid=1 and ptr=7 -> out_valid drops immediately. After release, the round-robin grant starts from channel 0.

Source files
------------

// File: rtl/stream_mux.sv
// stream_mux: N-to-1 valid/ready stream multiplexer with a one-entry
// registered output stage. Channel choice is an explicit select, or a
// round-robin arbiter when built with STREAM_MUX_RR_EN defined.
module stream_mux #(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 16,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      rr_mode,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // One extra bit so the channel count itself is representable.
  localparam logic [SEL_W:0]   CH_CNT = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(CHANNELS - 1);

  logic             accept;
  logic             sel_ok;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt;
  logic             xfer;
  logic [WIDTH-1:0] word;

  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] chan_p1;
  logic             vld_p1;

  // The output register can take a new word when empty or being drained.
  assign accept = !vld_p1 || out_ready;

  // An explicit select past the last channel grants nothing.
  assign sel_ok = ({1'b0, sel} < CH_CNT);

`ifdef STREAM_MUX_RR_EN
  logic [SEL_W-1:0] ptr;
  logic             rr_gnt_vld;
  logic [SEL_W-1:0] rr_gnt;
  logic [SEL_W:0]   idx;

  // Rotating-priority search: first valid channel at or after ptr, modulo CHANNELS.
  always_comb begin
    rr_gnt_vld = 1'b0;
    rr_gnt     = '0;
    idx        = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      // ptr < CHANNELS and i < CHANNELS, so one subtraction wraps the sum.
      idx = {1'b0, ptr} + (SEL_W+1)'(i);
      if (idx >= CH_CNT) begin
        idx = idx - CH_CNT;
      end
      if (!rr_gnt_vld && in_valid[idx[SEL_W-1:0]]) begin
        rr_gnt_vld = 1'b1;
        rr_gnt     = idx[SEL_W-1:0];
      end
    end
  end

  assign gnt_vld = rr_mode ? rr_gnt_vld : sel_ok;
  assign gnt     = rr_mode ? rr_gnt     : sel;

  // Pointer moves just past the channel that last transferred in round-robin mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (rr_mode && xfer) begin
      ptr <= (gnt == LAST) ? '0 : gnt + 1'b1;
    end
  end
`else
  logic unused_rr_mode;
  logic unused_last;

  assign gnt_vld        = sel_ok;
  assign gnt            = sel;
  assign unused_rr_mode = rr_mode;
  assign unused_last    = ^LAST;
`endif

  // One-hot ready toward the granted channel, held low during reset.
  always_comb begin
    in_ready = '0;
    if (gnt_vld && accept && rst_n) begin
      in_ready[gnt] = 1'b1;
    end
  end

  assign xfer = |(in_valid & in_ready);

  // Word of the granted channel; only consumed when a transfer happens.
  always_comb begin
    word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (SEL_W'(k) == gnt) begin
        word = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Stage p1: output register, filled on input transfer, emptied on drain only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      chan_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (xfer) begin
      data_p1 <= word;
      chan_p1 <= gnt;
      vld_p1  <= 1'b1;
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_data  = data_p1;
  assign out_chan  = chan_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_stream_mux.sv
// Directed self-checking bench for stream_mux: a 16-channel instance for the
// main scenarios and a 12-channel instance for out-of-range select.
module tb_stream_mux;

  localparam int W    = 32;
  localparam int CH   = 16;
  localparam int CH12 = 12;
  localparam int SW   = $clog2(CH);
  localparam int SW12 = $clog2(CH12);

  logic clk;
  logic rst_n;

  logic [CH*W-1:0]   in_data;
  logic [CH-1:0]     in_valid;
  logic [CH-1:0]     in_ready;
  logic [SW-1:0]     sel;
  logic              rr_mode;
  logic [W-1:0]      out_data;
  logic [SW-1:0]     out_chan;
  logic              out_valid;
  logic              out_ready;

  logic [CH12*W-1:0] in_data12;
  logic [CH12-1:0]   in_valid12;
  logic [CH12-1:0]   in_ready12;
  logic [SW12-1:0]   sel12;
  logic [W-1:0]      out_data12;
  logic [SW12-1:0]   out_chan12;
  logic              out_valid12;

  int checks = 0;
  int errors = 0;

  stream_mux #(.WIDTH(W), .CHANNELS(CH)) u16 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .rr_mode(rr_mode), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux #(.WIDTH(W), .CHANNELS(CH12)) u12 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data12), .in_valid(in_valid12),
    .in_ready(in_ready12), .sel(sel12), .rr_mode(1'b0), .out_data(out_data12),
    .out_chan(out_chan12), .out_valid(out_valid12), .out_ready(1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [W-1:0] v);
    in_data[k*W +: W] = v;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] d, input int c);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".data"},  64'(out_data),  64'(d));
    check({tag, ".chan"},  64'(out_chan),  64'(c));
  endtask

  initial begin
    rst_n      = 1'b0;
    rr_mode    = 1'b0;
    sel        = SW'(5);
    out_ready  = 1'b1;
    in_valid   = '1;
    for (int k = 0; k < CH; k++) set_ch(k, W'(32'hC000 + k));
    sel12      = SW12'(13);
    in_valid12 = '1;
    for (int k = 0; k < CH12; k++) in_data12[k*W +: W] = W'(32'hD000 + k);

    // Reset/idle with every channel valid.
    #2;
    check("rst.in_ready",   64'(in_ready),   64'd0);
    check("rst.out_valid",  64'(out_valid),  64'd0);
    check("rst.out_data",   64'(out_data),   64'd0);
    check("rst.out_chan",   64'(out_chan),   64'd0);
    check("rst.in_ready12", 64'(in_ready12), 64'd0);
    step();
    step();

    // Release reset; channel 5 streams 0xA0..0xA9 at one word per cycle.
    rst_n    = 1'b1;
    in_valid = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      set_ch(5, W'(32'hA0 + i));
      #1;
      check("fix.in_ready", 64'(in_ready), 64'h0020);
      if (i < 3) check("oor.in_ready12", 64'(in_ready12), 64'd0);
      step();
      check_out("fix", W'(32'hA0 + i), 5);
      if (i < 3) check("oor.out_valid12", 64'(out_valid12), 64'd0);
    end
    in_valid = '0;
    step();
    check("drain.out_valid", 64'(out_valid), 64'd0);
    check("drain.out_data",  64'(out_data),  64'hA9);

    // Valid in-range select on the 12-channel instance.
    sel12 = SW12'(11);
    #1;
    check("ch11.in_ready12", 64'(in_ready12), 64'h800);
    step();
    check("ch11.out_data12", 64'(out_data12), 64'hD00B);
    check("ch11.out_chan12", 64'(out_chan12), 64'd11);
    in_valid12 = '0;

    // Backpressure: first word 0x1234 held for 4 cycles while sel toggles.
    out_ready = 1'b0;
    in_valid  = 16'h0020;
    set_ch(5, 32'h1234);
    #1;
    check("bp.in_ready0", 64'(in_ready), 64'h0020);
    step();
    check_out("bp.first", 32'h1234, 5);
    set_ch(5, 32'h5678);
    in_valid = 16'h0024;
    for (int j = 0; j < 4; j++) begin
      sel = (j % 2 == 0) ? SW'(2) : SW'(5);
      #1;
      check("bp.in_ready", 64'(in_ready), 64'd0);
      step();
      check_out("bp.hold", 32'h1234, 5);
    end
    // Drain and fill in the same cycle.
    sel       = SW'(5);
    out_ready = 1'b1;
    #1;
    check("bp.refill.in_ready", 64'(in_ready), 64'h0020);
    step();
    check_out("bp.second", 32'h5678, 5);
    sel      = SW'(2);
    in_valid = 16'h0004;
    #1;
    check("bp.ch2.in_ready", 64'(in_ready), 64'h0004);
    step();
    check_out("bp.ch2", 32'hC002, 2);
    sel      = SW'(15);
    in_valid = 16'h8000;
    #1;
    check("ch15.in_ready", 64'(in_ready), 64'h8000);
    step();
    check_out("ch15", 32'hC00F, 15);
    in_valid = '0;
    step();
    check("bp.end.out_valid", 64'(out_valid), 64'd0);

    // Mid-stream reset discards a held word without waiting for a clock edge.
    out_ready = 1'b0;
    sel       = SW'(9);
    in_valid  = 16'h0200;
    step();
    check_out("mrst.pre", 32'hC009, 9);
    in_valid = '1;
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst.out_valid", 64'(out_valid), 64'd0);
    check("mrst.out_data",  64'(out_data),  64'd0);
    check("mrst.in_ready",  64'(in_ready),  64'd0);
    in_valid = '0;
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;

`ifdef STREAM_MUX_RR_EN
    // Round-robin over channels 0, 3, 15 including the 15 -> 0 wrap.
    begin
      int exp_seq[7] = '{0, 3, 15, 0, 3, 15, 0};
      rr_mode  = 1'b1;
      in_valid = 16'h8009;
      for (int i = 0; i < 7; i++) begin
        #1;
        check("rr.in_ready", 64'(in_ready), 64'(16'h1 << exp_seq[i]));
        step();
        check_out("rr", W'(32'hC000 + exp_seq[i]), exp_seq[i]);
      end
    end
    // Move ptr to 7, then reset while a word is held.
    in_valid = 16'h0040;
    step();
    check_out("rr.ptr7", 32'hC006, 6);
    in_valid  = '0;
    out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("rr.rst.out_valid", 64'(out_valid), 64'd0);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 16'h0408;
    #1;
    check("rr.after_rst.in_ready", 64'(in_ready), 64'h0008);
    step();
    check_out("rr.after_rst", 32'hC003, 3);
    in_valid = '0;
    rr_mode  = 1'b0;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
